// File: rtl/dnn_result_tx.sv
// Per-case result scorer and byte packer for the training loop: scores each case,
// packs eight results per byte, appends the epoch correct-count and queues bytes for UART TX.
module dnn_result_tx #(
  parameter int unsigned NOUT       = 10,
  parameter int unsigned NN         = 32,
  parameter int unsigned TC         = 12544,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            case_strobe,
  input  logic [NN-1:0]   act_in,
  input  logic [NOUT-1:0] ans_in,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [15:0]     epoch_correct,
  output logic            epoch_done,
  output logic            drop_err,
  output logic            ovf_err
);

  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] TcVal = 16'(TC);
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StCollect, StPushRes, StPushLo, StPushHi} state_e;

  state_e state_q, state_d;

  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [15:0]     case_cnt_q, case_cnt_d;
  logic [15:0]     run_cnt_q, run_cnt_d;
  logic [15:0]     epoch_correct_q, epoch_correct_d;
  logic            drop_err_q, drop_err_d;
  logic            ovf_err_q, ovf_err_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [OccW-1:0] occ_q, occ_d;

  logic            correct;
  logic            epoch_end;
  logic            push_req;
  logic [7:0]      push_byte;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;

  // Upper neuron outputs carry no class information.
  logic            unused_act;
  assign unused_act = ^act_in;

  assign correct   = (act_in[NOUT-1:0] == ans_in);
  assign epoch_end = (state_q == StPushRes) && (case_cnt_q == TcVal);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: begin
        if (case_strobe && (bit_idx_q == 3'd7)) begin
          state_d = StPushRes;
        end
      end
      StPushRes: state_d = epoch_end ? StPushLo : StCollect;
      StPushLo:  state_d = StPushHi;
      StPushHi:  state_d = StCollect;
      default:   state_d = StCollect;
    endcase
  end

  // FSM: outputs
  always_comb begin
    push_req   = 1'b0;
    push_byte  = 8'h00;
    epoch_done = 1'b0;
    unique case (state_q)
      StPushRes: begin
        push_req   = 1'b1;
        push_byte  = shift_q;
        epoch_done = epoch_end;
      end
      StPushLo: begin
        push_req  = 1'b1;
        push_byte = epoch_correct_q[7:0];
      end
      StPushHi: begin
        push_req  = 1'b1;
        push_byte = epoch_correct_q[15:8];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scoring datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_d         = shift_q;
    bit_idx_d       = bit_idx_q;
    case_cnt_d      = case_cnt_q;
    run_cnt_d       = run_cnt_q;
    epoch_correct_d = epoch_correct_q;
    drop_err_d      = drop_err_q | (case_strobe && (state_q != StCollect));
    unique case (state_q)
      StCollect: begin
        if (case_strobe) begin
          shift_d[bit_idx_q] = correct;
          run_cnt_d          = run_cnt_q + 16'(correct);
          case_cnt_d         = case_cnt_q + 16'd1;
          if (bit_idx_q != 3'd7) begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StPushRes: begin
        shift_d   = 8'h00;
        bit_idx_d = 3'd0;
        // The final case was already counted on its strobe.
        if (epoch_end) begin
          epoch_correct_d = run_cnt_q;
          run_cnt_d       = 16'd0;
          case_cnt_d      = 16'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q         <= 8'h00;
      bit_idx_q       <= 3'd0;
      case_cnt_q      <= 16'd0;
      run_cnt_q       <= 16'd0;
      epoch_correct_q <= 16'd0;
      drop_err_q      <= 1'b0;
    end else begin
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      case_cnt_q      <= case_cnt_d;
      run_cnt_q       <= run_cnt_d;
      epoch_correct_q <= epoch_correct_d;
      drop_err_q      <= drop_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  assign tx_valid  = (occ_q != '0);
  assign tx_data   = mem_q[rptr_q];
  assign fifo_full = (occ_q == OccFull);
  assign pop       = tx_valid && tx_ready;
  // A pop in the same clk frees the slot, so a full FIFO still accepts the push.
  assign push_ok   = push_req && (!fifo_full || pop);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    occ_d     = occ_q;
    ovf_err_d = ovf_err_q | (push_req && fifo_full && !pop);
    if (push_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push_ok && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (!push_ok && pop) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      occ_q     <= occ_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_byte;
    end
  end

  assign epoch_correct = epoch_correct_q;
  assign drop_err      = drop_err_q;
  assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_dnn_result_tx.sv
// Randomized and directed bench for dnn_result_tx against a timed transaction-level
// model: scheduled pushes per clk edge plus a byte queue standing in for the FIFO.
module tb_dnn_result_tx;

  localparam int unsigned TcB    = 16;
  localparam int unsigned DepthB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        case_strobe = 1'b0;
  logic [31:0] act_in = '0;
  logic [9:0]  ans_in = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] epoch_correct;
  logic        epoch_done;
  logic        drop_err;
  logic        ovf_err;

  always #5 clk = ~clk;

  dnn_result_tx #(
    .NOUT      (10),
    .NN        (32),
    .TC        (TcB),
    .FIFO_DEPTH(DepthB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .case_strobe  (case_strobe),
    .act_in       (act_in),
    .ans_in       (ans_in),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .epoch_correct(epoch_correct),
    .epoch_done   (epoch_done),
    .drop_err     (drop_err),
    .ovf_err      (ovf_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0]  exp_q[$];
  logic [7:0]  log_q[$];
  int          pend_t[$];
  logic [7:0]  pend_b[$];
  int          edge_no = 0;
  int          free_at = 0;
  int          ed_edge = -1;
  int          nbits = 0;
  int          cases = 0;
  int          run = 0;
  logic [7:0]  shv = '0;
  logic [15:0] ec_pend = '0;
  logic [15:0] exp_ec = '0;
  logic        exp_drop = 1'b0;
  logic        exp_ovf = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend_t.delete();
    pend_b.delete();
    free_at  = 0;
    ed_edge  = -1;
    nbits    = 0;
    cases    = 0;
    run      = 0;
    shv      = '0;
    exp_ec   = '0;
    exp_drop = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  // One clk: check outputs, drive inputs for the coming edge, advance the model.
  task automatic step(input logic stb, input logic [31:0] act, input logic [9:0] ans,
                      input logic rdy, input logic rst);
    int   e;
    logic do_pop;
    logic was_full;
    logic [7:0] b;
    @(negedge clk);
    check_eq("tx_valid", tx_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check_eq("tx_data", tx_data, exp_q[0]);
    check_eq("epoch_done", epoch_done, ed_edge == edge_no + 1);
    check_eq("epoch_correct", epoch_correct, exp_ec);
    check_eq("drop_err", drop_err, exp_drop);
    check_eq("ovf_err", ovf_err, exp_ovf);
    if (tx_valid && rdy && !rst) log_q.push_back(tx_data);
    reset       = rst;
    case_strobe = stb;
    act_in      = act;
    ans_in      = ans;
    tx_ready    = rdy;
    e = edge_no + 1;
    edge_no = e;
    if (rst) begin
      model_reset();
    end else begin
      was_full = (exp_q.size() == DepthB);
      do_pop   = (exp_q.size() > 0) && rdy;
      if (do_pop) void'(exp_q.pop_front());
      if (pend_t.size() > 0 && pend_t[0] == e) begin
        void'(pend_t.pop_front());
        b = pend_b.pop_front();
        if (was_full && !do_pop) exp_ovf = 1'b1;
        else exp_q.push_back(b);
      end
      if (stb) begin
        if (e >= free_at) begin
          if (act[9:0] == ans) begin
            shv[nbits] = 1'b1;
            run++;
          end
          nbits++;
          cases++;
          if (nbits == 8) begin
            pend_t.push_back(e + 1);
            pend_b.push_back(shv);
            shv     = '0;
            nbits   = 0;
            free_at = e + 2;
            if (cases == TcB) begin
              ed_edge = e + 1;
              ec_pend = 16'(run);
              pend_t.push_back(e + 2);
              pend_b.push_back(8'(run));
              pend_t.push_back(e + 3);
              pend_b.push_back(8'(run >> 8));
              run     = 0;
              cases   = 0;
              free_at = e + 4;
            end
          end
        end else begin
          exp_drop = 1'b1;
        end
      end
      if (e == ed_edge) exp_ec = ec_pend;
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 10'($urandom), rdy, 1'b0);
  endtask

  task automatic strobe_case(input bit corr, input int gap, input logic rdy);
    logic [9:0]  ans;
    logic [9:0]  flip;
    logic [31:0] act;
    ans  = 10'd1 << $urandom_range(9, 0);
    flip = 10'($urandom_range(1023, 1));
    act  = $urandom;
    act[9:0] = corr ? ans : (ans ^ flip);
    step(1'b1, act, ans, rdy, 1'b0);
    idle(gap, rdy);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b0, 1'b1);
    log_q.delete();
  endtask

  initial begin
    logic [7:0] pat;
    repeat (2) @(posedge clk);
    model_reset();

    // Single byte 0x8D: cases 0,2,3,7 correct
    do_reset();
    pat = 8'h8D;
    for (int i = 0; i < 8; i++) strobe_case(pat[i], 3, 1'b1);
    idle(4, 1'b1);
    check_eq("t1_nbytes", log_q.size(), 1);
    if (log_q.size() >= 1) check_eq("t1_byte", log_q[0], 8'h8D);

    // Full epoch of 16 cases, case 5 wrong
    do_reset();
    for (int i = 0; i < 16; i++) strobe_case(i != 5, 3, 1'b1);
    idle(6, 1'b1);
    check_eq("t2_nbytes", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check_eq("t2_b0", log_q[0], 8'hDF);
      check_eq("t2_b1", log_q[1], 8'hFF);
      check_eq("t2_b2", log_q[2], 8'h0F);
      check_eq("t2_b3", log_q[3], 8'h00);
    end
    check_eq("t2_epoch_correct", epoch_correct, 16'd15);

    // Upper act bits ignored; lower mismatch scored wrong
    do_reset();
    step(1'b1, 32'hFFFF_FC04, 10'h004, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 32'h0000_0006, 10'h004, 1'b1, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 6; i++) strobe_case(1'b1, 3, 1'b1);
    idle(4, 1'b1);
    check_eq("t3_nbytes", log_q.size(), 1);
    if (log_q.size() >= 1) check_eq("t3_byte", log_q[0], 8'hFD);

    // Overflow with tx_ready low, then drain
    do_reset();
    for (int i = 0; i < 72; i++) strobe_case(1'b1, 3, 1'b0);
    idle(2, 1'b0);
    check_eq("t4_ovf", ovf_err, 1'b1);
    log_q.delete();
    idle(20, 1'b1);
    check_eq("t4_drained", log_q.size(), DepthB);
    if (log_q.size() >= 1) check_eq("t4_first", log_q[0], 8'hFF);

    // Strobe during PUSH_RES is dropped
    do_reset();
    for (int i = 0; i < 7; i++) strobe_case(1'b1, 3, 1'b1);
    strobe_case(1'b1, 0, 1'b1);
    strobe_case(1'b0, 3, 1'b1);
    for (int i = 0; i < 8; i++) strobe_case(i != 0, 3, 1'b1);
    idle(8, 1'b1);
    check_eq("t5_drop", drop_err, 1'b1);
    check_eq("t5_nbytes", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check_eq("t5_b0", log_q[0], 8'hFF);
      check_eq("t5_b1", log_q[1], 8'hFE);
      check_eq("t5_b2", log_q[2], 8'h0F);
    end

    // Reset mid-operation discards queued and partial data
    do_reset();
    for (int i = 0; i < 11; i++) strobe_case(1'b1, 3, 1'b0);
    do_reset();
    @(negedge clk);
    check_eq("t6_valid_after_reset", tx_valid, 1'b0);
    pat = 8'h8D;
    for (int i = 0; i < 8; i++) strobe_case(pat[i], 3, 1'b1);
    idle(4, 1'b1);
    check_eq("t6_nbytes", log_q.size(), 1);
    if (log_q.size() >= 1) check_eq("t6_byte", log_q[0], 8'h8D);

    // Random traffic with occasional resets and back-to-back strobes
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [9:0]  ans;
      logic [31:0] act;
      ans = ($urandom_range(7, 0) == 0) ? 10'($urandom) : (10'd1 << $urandom_range(9, 0));
      act = $urandom;
      if ($urandom_range(9, 0) < 7) act[9:0] = ans;
      step($urandom_range(2, 0) == 0, act, ans, $urandom_range(3, 0) != 0,
           $urandom_range(399, 0) == 0);
    end
    idle(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dnn_result_tx.md
Name: dnn_result_tx

Overview:
- Output-side counterpart of the training-case feeder.
- Once per training case it captures the network's thresholded output vector and the ideal one-hot answer, and scores the case as correct or incorrect.
- It packs the per-case results into bytes and, at epoch end, appends the epoch's correct-count.
- It streams all of this as bytes through a small FIFO to the UART transmitter using a valid/ready handshake.

Parameters:
- NOUT, 10: output classes in the dataset; only these bits are scored.
- NN, 32: output-layer neuron count (width of act_in); must satisfy NN >= NOUT.
- TC, 12544: training cases per epoch; must satisfy TC % 8 == 0 and TC < 65536.
- FIFO_DEPTH, 8: byte FIFO depth; must be a power of 2, >= 4.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- case_strobe, input, 1: one-clk pulse marking that act_in/ans_in hold a completed case (a cycle_clk rising edge, detected in the clk domain).
- act_in, input, NN: thresholded network outputs for the case.
- ans_in, input, NOUT: ideal one-hot answer for the case.
- tx_data, output, 8: FIFO head byte.
- tx_valid, output, 1: FIFO non-empty.
- tx_ready, input, 1: UART TX accepts tx_data this clk.
- epoch_correct, output, 16: correct-count of the last completed epoch.
- epoch_done, output, 1: one-clk pulse when epoch_correct updates.
- drop_err, output, 1: sticky; set when a strobe is ignored because the FSM is busy.
- ovf_err, output, 1: sticky; set when a push is attempted while the FIFO is full.

Behaviour:
- Reset:
  - All outputs are 0; FIFO is empty; case counter, bit index, shift byte and running count are 0; FSM is in COLLECT.
  - Reset asserted mid-operation discards FIFO contents and any partial byte.
- Scoring:
  - correct = (act_in[NOUT-1:0] == ans_in).
  - act_in[NN-1:NOUT] is ignored.
  - Scoring is combinational and is sampled only on a strobe clk.
- FSM states: COLLECT, PUSH_RES, PUSH_LO, PUSH_HI.
- COLLECT with case_strobe:
  - Write correct into shift byte bit[bit_idx] (LSB = earliest case).
  - Add correct to the running count.
  - Increment the case counter.
  - If bit_idx == 7, go to PUSH_RES; otherwise increment bit_idx.
- PUSH_RES:
  - Push the shift byte; clear it and reset bit_idx to 0.
  - If the case counter == TC: latch epoch_correct = running count (including the final case), pulse epoch_done this clk, clear the running count and case counter, and go to PUSH_LO.
  - Otherwise go to COLLECT.
- PUSH_LO: push epoch_correct[7:0], then go to PUSH_HI.
- PUSH_HI: push epoch_correct[15:8], then go to COLLECT.
- Every FSM transition takes exactly one clk.
- A case_strobe seen in any state other than COLLECT is ignored and sets drop_err. The upstream strobe spacing of cpc (>= 4) normally prevents this.
- Byte latency: a result byte becomes tx_valid 2 clks after the strobe of its 8th case.
- Epoch stream order: TC/8 result bytes, then count LSB, then count MSB.
- FIFO:
  - tx_valid = !empty; tx_data = head; pop on tx_valid && tx_ready.
  - Push while full with no pop in the same clk: the byte is dropped and ovf_err is set; FSM still advances.
  - Push and pop in the same clk while full: both occur and occupancy is unchanged.
  - Push and pop in the same clk while empty: the pushed byte appears at the head on the next clk (no fall-through).
  - Read and write pointers wrap modulo FIFO_DEPTH; an occupancy counter distinguishes full from empty.
- Sticky flags clear only on reset.

Test Plan:
- Eight strobes with act_in==ans_in for cases 0,2,3,7 only, tx_ready=1 -> one byte 0x8D with tx_valid high 2 clks after the 8th strobe; epoch_done stays 0.
- TC overridden to 16; 16 strobes, all correct except case 5 -> bytes 0xDF, 0xFF, 0x0F, 0x00 in order; epoch_correct=15; epoch_done is a single pulse coincident with the push of 0xFF.
- act_in=32'hFFFF_FC04 (only bit 2 set among bits 0..9) with ans_in=10'h004 -> scored correct, since bits above NOUT are ignored; act_in=32'h0000_0006 with ans_in=10'h004 -> scored incorrect.
- tx_ready held 0, FIFO_DEPTH=8, 72 correct strobes -> 8 bytes 0xFF held, ovf_err=1 after the 9th push; releasing tx_ready drains exactly 8 bytes of 0xFF.
- Strobe asserted on the clk the FSM is in PUSH_RES -> drop_err=1; case counter not incremented; subsequent stream unaffected.
- Reset pulsed after 3 strobes and 2 queued bytes -> tx_valid=0 next clk; the next 8 strobes form a fresh byte starting at bit 0.
